// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU run WIDTH+1 cycles on operand magnitudes; MTHI/MTLO complete in IDLE.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_start,
  input  logic [2:0]       ex_op,
  input  logic [WIDTH-1:0] ex_srcA,
  input  logic [WIDTH-1:0] ex_srcB,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   is_div_q, is_div_d;
  logic                   neg_res_q, neg_res_d;
  logic                   neg_rem_q, neg_rem_d;
  logic                   dbz_q, dbz_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH:0]         rem_q, rem_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;

  logic                   start_arith;
  logic                   op_signed;
  logic                   op_is_div;
  logic                   sign_a, sign_b;
  logic [WIDTH-1:0]       mag_a, mag_b;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         rem_shift;
  logic [WIDTH:0]         trial;
  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;

  assign start_arith = (ex_op == OP_MULT) || (ex_op == OP_MULTU) ||
                       (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
  assign op_signed   = (ex_op == OP_MULT) || (ex_op == OP_DIV);
  assign op_is_div   = (ex_op == OP_DIV)  || (ex_op == OP_DIVU);
  assign sign_a      = op_signed && ex_srcA[WIDTH-1];
  assign sign_b      = op_signed && ex_srcB[WIDTH-1];
  assign mag_a       = sign_a ? (~ex_srcA + 1'b1) : ex_srcA;
  assign mag_b       = sign_b ? (~ex_srcB + 1'b1) : ex_srcB;

  // Shift-add multiply: multiplier sits in the low half of acc and retires LSB-first.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
  // Restoring divide: dividend bits shift out of a_q while quotient bits shift in.
  assign rem_shift = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, b_q};

  assign prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix   = dbz_q ? {WIDTH{1'b1}} : (neg_res_q ? (~a_q + 1'b1) : a_q);
  assign rem_fix   = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_start && !flush) begin
          if (start_arith) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = op_is_div;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            dbz_d     = op_is_div && (ex_srcB == '0);
            a_d       = mag_a;
            b_d       = mag_b;
            acc_d     = {{WIDTH{1'b0}}, mag_a};
            rem_d     = '0;
          end else if (ex_op == OP_MTHI) begin
            hi_d = ex_srcA;
          end else if (ex_op == OP_MTLO) begin
            lo_d = ex_srcA;
          end
        end
      end

      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d = trial[WIDTH] ? rem_shift : trial;
            a_d   = {a_q[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_FIX;
          end
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus randomized ops
// compared against a 64-bit arithmetic model of MIPS HI/LO semantics.
module tb_ex_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_start;
  logic [2:0]    ex_op;
  logic [W-1:0]  ex_srcA;
  logic [W-1:0]  ex_srcB;
  logic          flush;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic          busy;
  logic          done;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_start (ex_start),
    .ex_op    (ex_op),
    .ex_srcA  (ex_srcA),
    .ex_srcB  (ex_srcB),
    .flush    (flush),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy),
    .done     (done)
  );

  // Reference: {HI, LO} from plain 64-bit arithmetic (SV division truncates like MIPS).
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ref_result = 64'd0;
    case (op)
      3'd1: ref_result = 64'(sa * sb);
      3'd2: ref_result = ua * ub;
      3'd3: begin
        if (b == 32'd0) begin
          ref_result = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          ref_result = {r[31:0], q[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) ref_result = {a, 32'hFFFF_FFFF};
        else            ref_result = {32'(ua % ub), 32'(ua / ub)};
      end
      default: ref_result = 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h7FFF_FFFF;
      4:       v = 32'($urandom_range(0, 20));
      5:       v = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic drive_idle();
    ex_start = 1'b0;
    ex_op    = 3'd0;
    ex_srcA  = '0;
    ex_srcB  = '0;
    flush    = 1'b0;
  endtask

  // Leaves the bench at the first falling edge after the start was sampled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_start = 1'b1;
    ex_op    = op;
    ex_srcA  = a;
    ex_srcB  = b;
    @(negedge clk);
    ex_start = 1'b0;
    ex_op    = 3'd0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (hi_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset hi: got %h want 0", hi_out); end
    tests_run++; if (lo_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL reset lo: got %h want 0", lo_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset done: got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [8];
    int   c;
    vecs = '{
      '{3'd1, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
      '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{3'd4, 32'd7,         32'd0,          32'h0000_0007, 32'hFFFF_FFFF},
      '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{3'd3, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF},
      '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD}
    };
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(c);
      tests_run++; if (c != LAT) begin tests_failed++; $display("[TB] FAIL directed[%0d] busy cycles: got %0d want %0d", i, c, LAT); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL directed[%0d] done: got %b want 1", i, done); end
      tests_run++; if (hi_out !== vecs[i].hi) begin tests_failed++; $display("[TB] FAIL directed[%0d] hi: got %h want %h", i, hi_out, vecs[i].hi); end
      tests_run++; if (lo_out !== vecs[i].lo) begin tests_failed++; $display("[TB] FAIL directed[%0d] lo: got %h want %h", i, lo_out, vecs[i].lo); end
      @(negedge clk);
      tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL directed[%0d] done width: got %b want 0", i, done); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] hv, lv;
    hv = $urandom;
    lv = $urandom;
    issue(3'd5, hv, $urandom);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL mthi busy: got %b want 0", busy); end
    tests_run++; if (hi_out !== hv) begin tests_failed++; $display("[TB] FAIL mthi hi: got %h want %h", hi_out, hv); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL mthi done: got %b want 0", done); end
    issue(3'd6, lv, $urandom);
    tests_run++; if (lo_out !== lv) begin tests_failed++; $display("[TB] FAIL mtlo lo: got %h want %h", lo_out, lv); end
    tests_run++; if (hi_out !== hv) begin tests_failed++; $display("[TB] FAIL mtlo hi kept: got %h want %h", hi_out, hv); end
    issue(3'd0, $urandom, $urandom);
    issue(3'd7, $urandom, $urandom);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL nop busy: got %b want 0", busy); end
    tests_run++; if (hi_out !== hv || lo_out !== lv) begin tests_failed++; $display("[TB] FAIL nop hilo: got %h/%h want %h/%h", hi_out, lo_out, hv, lv); end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp;
    int          c;
    for (int i = 0; i < 30; i++) begin
      op  = 3'($urandom_range(1, 4));
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_result(op, a, b);
      issue(op, a, b);
      wait_idle(c);
      tests_run++; if (c != LAT) begin tests_failed++; $display("[TB] FAIL random[%0d] busy cycles: got %0d want %0d", i, c, LAT); end
      tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL random[%0d] done: got %b want 1", i, done); end
      tests_run++; if ({hi_out, lo_out} !== exp) begin tests_failed++; $display("[TB] FAIL random[%0d] op%0d %h,%h hilo: got %h want %h", i, op, a, b, {hi_out, lo_out}, exp); end
    end
  endtask

  task automatic test_flush();
    int c;
    issue(3'd5, 32'h0000_1234, 32'd0);
    issue(3'd6, 32'h5555_AAAA, 32'd0);
    issue(3'd2, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush calc busy: got %b want 0", busy); end
    tests_run++; if (hi_out !== 32'h1234 || lo_out !== 32'h5555_AAAA) begin tests_failed++; $display("[TB] FAIL flush calc hilo: got %h/%h want 00001234/5555aaaa", hi_out, lo_out); end
    tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush calc done: got %b want 0", done); end
    repeat (LAT) @(negedge clk);
    tests_run++; if (done !== 1'b0 || lo_out !== 32'h5555_AAAA) begin tests_failed++; $display("[TB] FAIL flush calc late: got done %b lo %h want 0 5555aaaa", done, lo_out); end

    issue(3'd1, 32'd7, 32'd9);
    repeat (W) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush fix pre-busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush fix state: got busy %b done %b want 0 0", busy, done); end
    tests_run++; if (hi_out !== 32'h1234 || lo_out !== 32'h5555_AAAA) begin tests_failed++; $display("[TB] FAIL flush fix hilo: got %h/%h want 00001234/5555aaaa", hi_out, lo_out); end

    @(negedge clk);
    ex_start = 1'b1; ex_op = 3'd5; ex_srcA = 32'h0000_0BAD; flush = 1'b1;
    @(negedge clk);
    ex_op = 3'd1; ex_srcA = 32'd4; ex_srcB = 32'd4;
    @(negedge clk);
    ex_start = 1'b0; flush = 1'b0;
    tests_run++; if (hi_out !== 32'h1234) begin tests_failed++; $display("[TB] FAIL flush idle mthi: got %h want 00001234", hi_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush idle start busy: got %b want 0", busy); end

    issue(3'd2, 32'd3, 32'd5);
    wait_idle(c);
    tests_run++; if (hi_out !== 32'd0 || lo_out !== 32'd15 || c != LAT) begin tests_failed++; $display("[TB] FAIL after flush op: got %h/%h in %0d want 0/f in %0d", hi_out, lo_out, c, LAT); end
  endtask

  task automatic test_busy_ignore();
    int c;
    issue(3'd4, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    ex_start = 1'b1; ex_op = 3'd6; ex_srcA = 32'h0000_00AA;
    @(negedge clk);
    ex_start = 1'b0; ex_op = 3'd0;
    wait_idle(c);
    tests_run++; if (c + 5 != LAT) begin tests_failed++; $display("[TB] FAIL ignore busy cycles: got %0d want %0d", c + 5, LAT); end
    tests_run++; if (lo_out !== 32'd14) begin tests_failed++; $display("[TB] FAIL ignore lo: got %h want 0000000e", lo_out); end
    tests_run++; if (hi_out !== 32'd2) begin tests_failed++; $display("[TB] FAIL ignore hi: got %h want 00000002", hi_out); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("[TB] FAIL ignore done: got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [63:0] exp;
    int          c;
    issue(3'd2, 32'd6, 32'd7);
    wait_idle(c);
    for (int i = 0; i < 3; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      exp = ref_result(3'd3, a, b);
      ex_start = 1'b1; ex_op = 3'd3; ex_srcA = a; ex_srcB = b;
      @(negedge clk);
      ex_start = 1'b0; ex_op = 3'd0;
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b[%0d] start on done: got busy %b want 1", i, busy); end
      wait_idle(c);
      tests_run++; if ({hi_out, lo_out} !== exp || c != LAT) begin tests_failed++; $display("[TB] FAIL b2b[%0d] %h/%h: got %h in %0d want %h in %0d", i, a, b, {hi_out, lo_out}, c, exp, LAT); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [63:0] exp;
    int          c;
    issue(3'd1, $urandom, $urandom);
    repeat (19) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    tests_run++; if (busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst mid state: got busy %b done %b want 0 0", busy, done); end
    tests_run++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin tests_failed++; $display("[TB] FAIL rst mid hilo: got %h/%h want 0/0", hi_out, lo_out); end
    @(negedge clk);
    rst = 1'b0;
    a   = pick_operand();
    b   = pick_operand();
    exp = ref_result(3'd1, a, b);
    issue(3'd1, a, b);
    wait_idle(c);
    tests_run++; if ({hi_out, lo_out} !== exp || c != LAT || done !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst recover %h*%h: got %h in %0d done %b want %h in %0d", a, b, {hi_out, lo_out}, c, done, exp, LAT); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_random();
    test_flush();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
